ysyx_25060170_ifu: RTL and testbench
====================================

# ysyx_25060170_ifu

Instruction fetch unit for the single-issue ysyx_25060170 core. Holds the architectural PC and fetches one instruction at a time over a valid/ready request/response port to instruction memory. Presents {pc, inst} to the decode stage under a valid/ready handshake, then waits for writeback to retire the instruction. Computes the next PC from the writeback redirect (jal/jalr) or PC+4.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid (registered)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch address, equals current PC
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction word
- imem_rsp_err  in  1  access fault on this response
- out_valid  out  1  {pc_o, inst_o} valid to decode
- out_ready  in  1  decode accepts instruction
- pc_o  out  32  PC of presented instruction
- inst_o  out  32  presented instruction word
- wb_valid  in  1  current instruction retired this cycle
- jump_en  in  1  redirect, sampled with wb_valid
- dnpc_i  in  32  redirect target, sampled with wb_valid
- fetch_err  out  1  sticky fault flag; unit halted
- retired_cnt  out  32  retired instruction count

## Operation
- States: IDLE, REQ, WAIT, DECODE, EXEC, HALT.
- Reset (async, any state): state=IDLE, pc=RESET_PC, imem_req_valid=0, out_valid=0, inst_o=0, fetch_err=0, retired_cnt=0; imem_req_addr=pc_o=RESET_PC.
- IDLE -> REQ unconditionally on the first clock after rst deasserts.
- REQ: imem_req_valid=1, imem_req_addr=pc. If imem_req_ready=1, then -> WAIT. Address stays stable while ready=0.
- WAIT: imem_req_valid=0. On imem_rsp_valid:
  - rsp_err=0: inst_o<=imem_rsp_data, -> DECODE.
  - rsp_err=1: fetch_err<=1, -> HALT.
- DECODE: out_valid=1, pc_o/inst_o held stable. On out_ready=1, -> EXEC.
- EXEC: out_valid=0. On wb_valid=1:
  - npc = jump_en ? {dnpc_i[31:1],1'b0} : pc+32'd4, wrapping modulo 2^32.
  - retired_cnt increments, wrapping modulo 2^32.
  - If npc[1]=1 (misaligned): fetch_err<=1, pc<=npc, -> HALT.
  - Otherwise pc<=npc, -> REQ.
- HALT: all valids 0, state frozen until rst. Ebreak/exit is not this block's concern.
- Ignored inputs:
  - imem_rsp_valid outside WAIT has no effect.
  - wb_valid outside EXEC has no effect.
  - jump_en and dnpc_i are don't-care when wb_valid=0.

## Timing
- All outputs registered except imem_req_addr and pc_o, which are direct from the pc register.
- A response may arrive no earlier than the cycle after request acceptance. A response in the acceptance cycle is ignored.
- Minimum per-instruction latency with all handshakes immediate is 4 cycles: REQ, WAIT, DECODE, EXEC.
- First request is visible (imem_req_valid=1) in the 2nd cycle after reset release.
- out_valid, once high, stays high with stable data until out_ready; no retraction.
- imem_req_valid, once high, stays high with stable address until imem_req_ready.
- Redirect takes effect on the very next request; no wrong-path fetch is ever issued.
- Reset asserted mid-transaction (REQ/WAIT) abandons it. A late response after reset lands in IDLE/REQ and is ignored.

## Test plan
- Reset release, ready=1, rsp 1 cycle later with data 32'h00000413:
  - req addr 32'h80000000 in cycle 2.
  - out_valid in cycle 4 with pc_o=32'h80000000, inst_o=32'h00000413.
- Sequential flow, 3 retirements with jump_en=0:
  - req addrs 80000000, 80000004, 80000008.
  - retired_cnt=3.
- Redirect: wb_valid=1, jump_en=1, dnpc_i=32'h80000101 -> next req addr 32'h80000100.
- Backpressure: imem_req_ready=0 for 5 cycles, then out_ready=0 for 3 cycles -> addr and pc_o/inst_o stable throughout, exactly one fetch.
- Faults:
  - imem_rsp_err=1 -> fetch_err=1, no out_valid, no further requests.
  - Separately, dnpc_i=32'h80000006 with jump_en=1 -> fetch_err=1, HALT.
- Edges:
  - pc=32'hFFFFFFFC sequential retire -> next addr 32'h00000000.
  - rst asserted during WAIT, then stray rsp_valid -> ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_25060170_ifu_if.sv
// Fetch-side bundle of the ysyx_25060170 IFU: instruction-memory request/response,
// the decode handshake and the writeback retire strobe.
interface ysyx_25060170_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        wb_valid;
  logic        jump_en;
  logic [31:0] dnpc_i;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, pc_o, inst_o,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  out_ready, wb_valid, jump_en, dnpc_i
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, pc_o, inst_o,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output out_ready, wb_valid, jump_en, dnpc_i
  );
endinterface

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: one instruction in flight, fetched, handed to decode,
// then held until writeback retires it and supplies the next PC.
module ysyx_25060170_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_25060170_ifu_if.master       bus,
  output logic                      fetch_err,
  output logic [31:0]               retired_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        req_valid_q, req_valid_d;
  logic        out_valid_q, out_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] npc;

  // Redirect targets are forced halfword-aligned; bit 1 is left for the fault check.
  assign npc = bus.jump_en ? {bus.dnpc_i[31:1], 1'b0} : pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    req_valid_d   = req_valid_q;
    out_valid_d   = out_valid_q;
    fetch_err_d   = fetch_err_q;
    retired_cnt_d = retired_cnt_q;
    case (state_q)
      IDLE: begin
        state_d     = REQ;
        req_valid_d = 1'b1;
      end
      REQ: begin
        if (bus.imem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (bus.imem_rsp_err) begin
            fetch_err_d = 1'b1;
            state_d     = HALT;
          end else begin
            inst_d      = bus.imem_rsp_data;
            out_valid_d = 1'b1;
            state_d     = DECODE;
          end
        end
      end
      DECODE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (bus.wb_valid) begin
          pc_d          = npc;
          retired_cnt_d = retired_cnt_q + 32'd1;
          if (npc[1]) begin
            fetch_err_d = 1'b1;
            state_d     = HALT;
          end else begin
            req_valid_d = 1'b1;
            state_d     = REQ;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        req_valid_d = 1'b0;
        out_valid_d = 1'b0;
        state_d     = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= 32'd0;
      req_valid_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      fetch_err_q   <= 1'b0;
      retired_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      req_valid_q   <= req_valid_d;
      out_valid_q   <= out_valid_d;
      fetch_err_q   <= fetch_err_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.pc_o           = pc_q;
  assign bus.inst_o         = inst_q;
  assign fetch_err          = fetch_err_q;
  assign retired_cnt        = retired_cnt_q;

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Directed and randomized bench for ysyx_25060170_ifu against a transaction-level
// model that only tracks architectural PC, retire count and the halted flag.
module tb_ysyx_25060170_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_err;
  logic [31:0] retired_cnt;

  ysyx_25060170_ifu_if ifc ();

  ysyx_25060170_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the architecture says, not how the FSM gets there.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_halted;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = 32'd0;
    ifc.imem_rsp_err   = 1'b0;
    ifc.out_ready      = 1'b0;
    ifc.wb_valid       = 1'b0;
    ifc.jump_en        = 1'b0;
    ifc.dnpc_i         = 32'd0;
  endtask

  // Reset, check reset values, release and check the first request appears next cycle.
  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1 ("rst_req_valid", ifc.imem_req_valid, 1'b0);
    chk1 ("rst_out_valid", ifc.out_valid, 1'b0);
    chk32("rst_addr", ifc.imem_req_addr, RESET_PC);
    chk32("rst_pc_o", ifc.pc_o, RESET_PC);
    chk32("rst_inst_o", ifc.inst_o, 32'd0);
    chk1 ("rst_fetch_err", fetch_err, 1'b0);
    chk32("rst_retired", retired_cnt, 32'd0);
    rst = 1'b0;
    m_pc = RESET_PC;
    m_cnt = 32'd0;
    m_halted = 1'b0;
    @(negedge clk);
    chk1 ("first_req_valid", ifc.imem_req_valid, 1'b1);
    chk32("first_req_addr", ifc.imem_req_addr, RESET_PC);
  endtask

  // One instruction end to end. Entered with the request expected visible.
  task automatic fetch_one(input int req_dly, input logic [31:0] data, input bit err,
                           input int rsp_dly, input int dec_dly, input int wb_dly,
                           input bit jmp, input logic [31:0] dnpc, input bit strays);
    logic [31:0] npc;
    chk1 ("req_valid", ifc.imem_req_valid, 1'b1);
    chk32("req_addr", ifc.imem_req_addr, m_pc);
    for (int i = 0; i < req_dly; i++) begin
      ifc.imem_req_ready = 1'b0;
      ifc.imem_rsp_valid = strays & $urandom_range(0, 1);
      ifc.imem_rsp_err   = strays & $urandom_range(0, 1);
      @(negedge clk);
      chk1 ("req_hold_valid", ifc.imem_req_valid, 1'b1);
      chk32("req_hold_addr", ifc.imem_req_addr, m_pc);
    end
    ifc.imem_req_ready = 1'b1;
    ifc.imem_rsp_valid = strays;
    ifc.imem_rsp_err   = strays;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_err   = 1'b0;
    chk1("req_dropped", ifc.imem_req_valid, 1'b0);
    chk1("accept_cycle_rsp_ignored", fetch_err, 1'b0);
    for (int i = 0; i < rsp_dly; i++) begin
      @(negedge clk);
      chk1("wait_out_valid", ifc.out_valid, 1'b0);
    end
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = data;
    ifc.imem_rsp_err   = err;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_err   = 1'b0;
    if (err) begin
      m_halted = 1'b1;
      chk1("rsp_err_fetch_err", fetch_err, 1'b1);
      chk1("rsp_err_out_valid", ifc.out_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk1("halt_no_req", ifc.imem_req_valid, 1'b0);
        chk1("halt_no_out", ifc.out_valid, 1'b0);
      end
      return;
    end
    chk1 ("out_valid", ifc.out_valid, 1'b1);
    chk32("out_pc", ifc.pc_o, m_pc);
    chk32("out_inst", ifc.inst_o, data);
    for (int i = 0; i < dec_dly; i++) begin
      ifc.out_ready = 1'b0;
      ifc.wb_valid  = strays;
      ifc.jump_en   = 1'b1;
      ifc.dnpc_i    = $urandom;
      @(negedge clk);
      ifc.wb_valid  = 1'b0;
      chk1 ("out_hold_valid", ifc.out_valid, 1'b1);
      chk32("out_hold_pc", ifc.pc_o, m_pc);
      chk32("out_hold_inst", ifc.inst_o, data);
      chk32("stray_wb_retired", retired_cnt, m_cnt);
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk1("out_dropped", ifc.out_valid, 1'b0);
    for (int i = 0; i < wb_dly; i++) begin
      ifc.jump_en = $urandom_range(0, 1);
      ifc.dnpc_i  = $urandom;
      @(negedge clk);
      chk1("exec_no_req", ifc.imem_req_valid, 1'b0);
    end
    ifc.wb_valid = 1'b1;
    ifc.jump_en  = jmp;
    ifc.dnpc_i   = dnpc;
    @(negedge clk);
    ifc.wb_valid = 1'b0;
    ifc.jump_en  = 1'b0;
    npc = jmp ? (dnpc & ~32'd1) : m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
    m_pc = npc;
    m_halted = (npc % 4) >= 2;
    chk32("retired_cnt", retired_cnt, m_cnt);
    chk1 ("wb_fetch_err", fetch_err, m_halted);
    chk32("next_pc", ifc.pc_o, m_pc);
    chk1 ("next_req_valid", ifc.imem_req_valid, !m_halted);
    if (m_halted) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk1("mis_halt_no_req", ifc.imem_req_valid, 1'b0);
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    drive_idle();

    // Bring-up timing: out_valid in cycle 4 with the first word.
    do_reset();
    fetch_one(0, 32'h00000413, 1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b0);
    // Two more sequential retirements -> count 3, addresses step by 4.
    fetch_one(0, 32'h00100093, 1'b0, 0, 0, 1, 1'b0, 32'd0, 1'b0);
    fetch_one(0, 32'h00200113, 1'b0, 1, 0, 0, 1'b0, 32'd0, 1'b0);
    chk32("seq_cnt3", retired_cnt, 32'd3);
    chk32("seq_addr", ifc.imem_req_addr, 32'h8000000C);

    // Redirect with odd target drops bit 0.
    fetch_one(0, 32'h0000006f, 1'b0, 0, 0, 0, 1'b1, 32'h80000101, 1'b0);
    chk32("redirect_addr", ifc.imem_req_addr, 32'h80000100);

    // Backpressure on both sides, with stray rsp/wb pulses that must be ignored.
    fetch_one(5, 32'hdeadbeef, 1'b0, 2, 3, 2, 1'b0, 32'd0, 1'b1);

    // Wrap at top of address space.
    fetch_one(0, 32'h0000006f, 1'b0, 0, 0, 0, 1'b1, 32'hFFFFFFFC, 1'b0);
    fetch_one(0, 32'h00000013, 1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b0);
    chk32("wrap_addr", ifc.imem_req_addr, 32'h00000000);

    // Access fault halts.
    fetch_one(0, 32'h00000013, 1'b1, 0, 0, 0, 1'b0, 32'd0, 1'b0);

    // Misaligned redirect halts.
    do_reset();
    fetch_one(0, 32'h0000006f, 1'b0, 0, 0, 0, 1'b1, 32'h80000006, 1'b0);
    chk32("misalign_pc", ifc.pc_o, 32'h80000006);

    // Reset during WAIT, stray response right after release.
    do_reset();
    fetch_one(0, 32'h00000013, 1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b0);
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk32("midrst_retired", retired_cnt, 32'd0);
    chk32("midrst_addr", ifc.imem_req_addr, RESET_PC);
    rst = 1'b0;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_err   = 1'b1;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_err   = 1'b0;
    m_pc = RESET_PC; m_cnt = 32'd0; m_halted = 1'b0;
    chk1("late_rsp_fetch_err", fetch_err, 1'b0);
    fetch_one(0, 32'h12345678, 1'b0, 0, 0, 0, 1'b0, 32'd0, 1'b0);

    // Randomized run against the model.
    for (int n = 0; n < 40; n++) begin
      if (m_halted) do_reset();
      d = 32'h80000000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      fetch_one($urandom_range(0, 3), $urandom, ($urandom_range(0, 19) == 0),
                $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
                ($urandom_range(0, 2) == 0), d, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
